// File: rtl/project_select_ctrl.sv
// project_select_ctrl: Wishbone-slave owner of the one-hot `active` vector that
// selects which user project drives the shared io/la buses. Switching is
// break-before-make: old project off, all-zero `active` for `gap` cycles, a
// one-cycle MAKE that commits the pending selection, then the new project on.
//
// Ports:
//   wb_clk_i, wb_rst_n         clock, synchronous active-low reset
//   wbs_stb_i/cyc_i/we_i       Wishbone request qualifiers
//   wbs_sel_i[3:0]             byte enables
//   wbs_dat_i[31:0]            write data
//   wbs_adr_i[31:0]            byte address (window of 3 registers at BASE_ADDR)
//   wbs_ack_o, wbs_dat_o       one-cycle acknowledge, read data valid with ack
//   active[31:0]               one-hot project enable (onehot0 every cycle)
//   busy                       switch sequence in progress
//   switch_done                pulse in the first cycle the new selection drives
module project_select_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned NUM_PROJECTS = 32,
    parameter logic [7:0]  GAP_DEFAULT  = 8'd4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] active,
    output logic        busy,
    output logic        switch_done
);

    localparam int unsigned DW    = 32;
    localparam int unsigned SEL_W = 5;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic [SEL_W-1:0]   cur_sel, cur_sel_n;
    logic               cur_en, cur_en_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [DW-1:0]      active_n;
    logic               busy_n;
    logic               switch_done_n;

    logic [SEL_W-1:0]   pend_sel;
    logic               pend_en;
    logic [GAP_W-1:0]   gap;
    logic               err;

    logic               wb_hit;
    logic               wb_req;
    logic               ctrl_wr;
    logic               gap_wr;
    logic [1:0]         reg_off;
    logic [7:0]         wr_idx;
    logic               wr_en;
    logic               wr_bad;
    logic [GAP_W-1:0]   gap_wr_val;
    logic [DW-1:0]      rdata;
    logic               sel_differs;
    logic               unused_bits;

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:9]};

    // Wishbone request decode; ack suppresses a re-issue in the ack cycle
    assign wb_hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wb_req  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & wb_hit;
    assign reg_off = wbs_adr_i[3:2];
    assign ctrl_wr = wb_req & wbs_we_i & (reg_off == 2'd0);
    assign gap_wr  = wb_req & wbs_we_i & (reg_off == 2'd2) & wbs_sel_i[0];

    // CTRL write merged per byte lane. The whole low byte is range-checked so
    // an index above the 5-bit field (e.g. 0x20) is rejected, not aliased.
    assign wr_idx     = wbs_sel_i[0] ? wbs_dat_i[7:0] : 8'(pend_sel);
    assign wr_en      = wbs_sel_i[1] ? wbs_dat_i[8] : pend_en;
    assign wr_bad     = wr_en && (32'(wr_idx) >= NUM_PROJECTS);
    assign gap_wr_val = (wbs_dat_i[7:0] == 8'd0) ? GAP_W'(1) : wbs_dat_i[7:0];

    // Selection differs; cur_sel is a don't-care when both are disabled
    assign sel_differs = (pend_en != cur_en) || (pend_en && (pend_sel != cur_sel));

    // Register read mux
    always_comb begin
        rdata = '0;
        case (reg_off)
            2'd0:    rdata = {23'd0, pend_en, 3'd0, pend_sel};
            2'd1:    rdata = {8'd0, count, 5'd0, err, busy, cur_en, 3'd0, cur_sel};
            2'd2:    rdata = {24'd0, gap};
            default: rdata = '0;
        endcase
    end

    // Wishbone-side registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            pend_sel  <= '0;
            pend_en   <= 1'b0;
            gap       <= GAP_DEFAULT;
            err       <= 1'b0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= (wb_req && !wbs_we_i) ? rdata : '0;
            if (ctrl_wr) begin
                if (wr_bad) begin
                    err <= 1'b1;
                end else begin
                    err      <= 1'b0;
                    pend_sel <= wr_idx[SEL_W-1:0];
                    pend_en  <= wr_en;
                end
            end
            if (gap_wr) begin
                gap <= gap_wr_val;
            end
        end
    end

    // Switch FSM next-state and registered-output computation
    always_comb begin
        state_n       = state;
        gap_cnt_n     = gap_cnt;
        cur_sel_n     = cur_sel;
        cur_en_n      = cur_en;
        count_n       = count;
        switch_done_n = 1'b0;

        case (state)
            IDLE: begin
                if (sel_differs) begin
                    state_n   = BREAK;
                    gap_cnt_n = gap;
                end
            end
            BREAK: begin
                gap_cnt_n = gap_cnt - GAP_W'(1);
                if (gap_cnt == GAP_W'(1)) begin
                    state_n = MAKE;
                end
            end
            MAKE: begin
                cur_sel_n     = pend_sel;
                cur_en_n      = pend_en;
                count_n       = count + CNT_W'(1);
                switch_done_n = 1'b1;
                state_n       = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they track the state
        // they belong to in the same cycle.
        active_n = ((state_n == IDLE) && cur_en_n) ? (DW'(1) << cur_sel_n) : '0;
        busy_n   = (state_n != IDLE);
    end

    // Switch FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            cur_sel     <= '0;
            cur_en      <= 1'b0;
            count       <= '0;
            active      <= '0;
            busy        <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            state       <= state_n;
            gap_cnt     <= gap_cnt_n;
            cur_sel     <= cur_sel_n;
            cur_en      <= cur_en_n;
            count       <= count_n;
            active      <= active_n;
            busy        <= busy_n;
            switch_done <= switch_done_n;
        end
    end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Testbench for project_select_ctrl: directed steps plus randomized selection
// requests checked against a transaction-level model of the register file and
// the break-before-make timeline.
module tb_project_select_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_GAP  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic [31:0] active;
    logic        busy, switch_done;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    // Reference model state
    bit          cur_en_m, pend_en_m, err_m;
    logic [4:0]  cur_sel_m, pend_sel_m;
    logic [7:0]  gap_m, count_m;

    project_select_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (dat_i),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .active      (active),
        .busy        (busy),
        .switch_done (switch_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Shared buses must never see two enabled projects
    always @(negedge clk) begin
        tests++;
        assert ($onehot0(active)) else begin
            fails++;
            $error("FAIL onehot0: active=0x%08h", active);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] onehot_of(input bit en, input logic [4:0] s);
        return en ? (32'h1 << s) : 32'h0;
    endfunction

    function automatic logic [31:0] status_exp();
        return {8'h00, count_m, 5'd0, err_m, 1'b0, cur_en_m, 3'd0, cur_sel_m};
    endfunction

    function automatic logic [31:0] ctrl_exp();
        return {23'd0, pend_en_m, 3'd0, pend_sel_m};
    endfunction

    // One Wishbone transfer; returns at the negedge of the ack cycle (lat=0: no ack)
    task automatic wb_xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(negedge clk);
        adr = a; we = w; dat_i = d; sel = s; stb = 1'b1; cyc = 1'b1;
        lat = 0;
        rd  = '0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (ack) begin
                lat = n;
                rd  = dat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        wb_xfer(a, 1'b1, d, s, rd, lat);
        chk({tag, "_ack_lat"}, 32'(lat), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        wb_xfer(a, 1'b0, 32'h0, 4'hF, rd, lat);
        chk({tag, "_ack_lat"}, 32'(lat), 32'd1);
        chk(tag, rd, exp);
    endtask

    // Called at the negedge of the CTRL write's ack cycle A
    task automatic run_window(input string tag, input logic [31:0] old_a,
                              input logic [31:0] new_a, input bit sw, input int g);
        logic [31:0] exp;
        chk({tag, "_active_at_ack"}, active, old_a);
        for (int k = 1; k <= g + 3; k++) begin
            @(negedge clk);
            if (sw) exp = (k <= g + 1) ? 32'h0 : new_a;
            else    exp = old_a;
            chk({tag, "_active"}, active, exp);
            chk({tag, "_switch_done"}, 32'(switch_done), 32'(sw && (k == g + 2)));
            chk({tag, "_busy"}, 32'(busy), 32'(sw && (k <= g + 1)));
        end
    endtask

    task automatic model_reset();
        cur_en_m = 0; pend_en_m = 0; err_m = 0;
        cur_sel_m = '0; pend_sel_m = '0;
        gap_m = 8'd4; count_m = 8'd0;
    endtask

    // Apply a CTRL write to the model; returns whether a switch follows
    task automatic model_ctrl(input logic [7:0] idx, input bit en, output bit sw,
                              output logic [31:0] old_a, output logic [31:0] new_a);
        old_a = onehot_of(cur_en_m, cur_sel_m);
        new_a = old_a;
        sw    = 0;
        if (en && idx >= 8'd32) begin
            err_m = 1;
        end else begin
            err_m      = 0;
            pend_en_m  = en;
            pend_sel_m = idx[4:0];
            sw = (pend_en_m != cur_en_m) || (pend_en_m && pend_sel_m != cur_sel_m);
            if (sw) begin
                new_a     = onehot_of(pend_en_m, pend_sel_m);
                cur_en_m  = pend_en_m;
                cur_sel_m = pend_sel_m;
                count_m   = count_m + 8'd1;
            end
        end
    endtask

    initial begin
        logic [31:0] rd, old_a, new_a;
        int          lat, c_a;
        bit          sw, seen20;
        logic [7:0]  idx;
        bit          en;
        int          g, kind;

        rst_n = 1'b0; stb = 0; cyc = 0; we = 0; sel = 4'h0; dat_i = '0; adr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_active", active, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_switch_done", 32'(switch_done), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_dat_o", dat_o, 32'h0);
        rst_n = 1'b1;

        // Register reads after reset
        rd_chk("status_rst", A_STAT, status_exp());
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack), 32'h0);
        chk("dat_o_idle", dat_o, 32'h0);
        rd_chk("gap_rst", A_GAP, 32'h4);
        rd_chk("rsv_read", A_RSV, 32'h0);
        wr("rsv_write", A_RSV, 32'hFFFF_FFFF, 4'hF);

        // Outside the window: no ack, no effect
        wb_xfer(BASE + 32'h10, 1'b1, 32'h0000_0105, 4'hF, rd, lat);
        chk("oow_no_ack", 32'(lat), 32'd0);
        rd_chk("ctrl_after_oow", A_CTRL, ctrl_exp());

        // First selection: project 3 with default gap 4
        wr("sel3", A_CTRL, 32'h0000_0103, 4'hF);
        model_ctrl(8'd3, 1'b1, sw, old_a, new_a);
        run_window("sel3", old_a, new_a, sw, 4);
        rd_chk("status_sel3", A_STAT, 32'h0001_0103);
        rd_chk("ctrl_sel3", A_CTRL, 32'h0000_0103);

        // GAP=0 is stored as 1, then switch 3 -> 1
        wr("gap0", A_GAP, 32'h0, 4'hF);
        gap_m = 8'd1;
        rd_chk("gap_min", A_GAP, 32'h1);
        wr("sel1", A_CTRL, 32'h0000_0101, 4'hF);
        model_ctrl(8'd1, 1'b1, sw, old_a, new_a);
        run_window("sel1", old_a, new_a, sw, 1);
        rd_chk("status_sel1", A_STAT, 32'h0002_0101);

        // Latest pending request wins; no restart of the in-flight sequence
        wr("gap6", A_GAP, 32'h6, 4'hF);
        gap_m = 8'd6;
        wr("sel5", A_CTRL, 32'h0000_0105, 4'hF);
        c_a = cyc_n;
        chk("sel5_active_at_ack", active, 32'h2);
        wr("sel2_in_break", A_CTRL, 32'h0000_0102, 4'hF);
        chk("busy_in_break", 32'(busy), 32'h1);
        seen20 = 0;
        for (int n = 0; n < 20; n++) begin
            if (active == 32'h20) seen20 = 1;
            if (active != 32'h0) break;
            @(negedge clk);
        end
        chk("no_intermediate", 32'(seen20), 32'h0);
        chk("merge_latency", 32'(cyc_n - c_a), 32'd8);
        chk("merge_active", active, 32'h4);
        chk("merge_switch_done", 32'(switch_done), 32'h1);
        model_ctrl(8'd5, 1'b1, sw, old_a, new_a);
        model_ctrl(8'd2, 1'b1, sw, old_a, new_a);
        count_m = count_m - 8'd1;
        cur_sel_m = 5'd2; pend_sel_m = 5'd2;
        repeat (10) @(negedge clk);
        chk("merge_settled", active, 32'h4);
        chk("merge_busy", 32'(busy), 32'h0);
        rd_chk("status_merge", A_STAT, 32'h0003_0102);

        // Out-of-range index sets err and leaves everything alone
        wr("bad32", A_CTRL, 32'h0000_0120, 4'hF);
        model_ctrl(8'h20, 1'b1, sw, old_a, new_a);
        run_window("bad32", old_a, new_a, sw, 6);
        rd_chk("status_err", A_STAT, status_exp());
        // Rewriting the current selection clears err without a switch
        wr("same2", A_CTRL, 32'h0000_0102, 4'hF);
        model_ctrl(8'd2, 1'b1, sw, old_a, new_a);
        run_window("same2", old_a, new_a, sw, 6);
        rd_chk("status_err_clr", A_STAT, 32'h0003_0102);

        // Byte lane 0 only: index changes, enable is kept
        wr("lane0", A_CTRL, 32'hFFFF_FE06, 4'h1);
        model_ctrl(8'd6, 1'b1, sw, old_a, new_a);
        run_window("lane0", old_a, new_a, sw, 6);
        rd_chk("ctrl_lane0", A_CTRL, 32'h0000_0106);

        // Randomized requests against the model
        for (int i = 0; i < 12; i++) begin
            g = $urandom_range(1, 5);
            wr("rnd_gap", A_GAP, 32'(g), 4'hF);
            gap_m = 8'(g);
            kind = $urandom_range(0, 9);
            en   = (kind != 0) && (i != 3);
            idx  = (kind >= 8) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
            wr("rnd_ctrl", A_CTRL, {23'd0, en, idx}, 4'hF);
            model_ctrl(idx, en, sw, old_a, new_a);
            run_window("rnd", old_a, new_a, sw, g);
            rd_chk("rnd_status", A_STAT, status_exp());
            rd_chk("rnd_ctrl_rb", A_CTRL, ctrl_exp());
        end

        // Reset mid-BREAK aborts the switch
        wr("gap5", A_GAP, 32'h5, 4'hF);
        wr("pre_rst", A_CTRL, {23'd1, 1'b1, 3'd0, cur_sel_m + 5'd1}, 4'hF);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("midrst_active", active, 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        repeat (8) @(negedge clk);
        chk("postrst_active", active, 32'h0);
        rd_chk("postrst_status", A_STAT, 32'h0);
        rd_chk("postrst_gap", A_GAP, 32'h4);
        rd_chk("postrst_ctrl", A_CTRL, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/project_select_ctrl.md
Name: project_select_ctrl

Overview:
- Wishbone-slave controller that owns the 32-bit one-hot `active` vector selecting which user project drives the shared io/la buses.
- Guarantees break-before-make switching: the old project is deselected, then all-zero `active` is held for a programmable gap, then the new project is selected.
- `active` is onehot0 on every cycle, so tristated shared outputs never contend.
- Sits in user_project_wrapper between the Caravel Wishbone port and the wrapped project instances.

Parameters:
- BASE_ADDR, 32'h3000_0000, word-aligned base of the 3-register window (adr[31:4] compared).
- NUM_PROJECTS, 32, number of valid project indices (1..32); indices >= NUM_PROJECTS are rejected.
- GAP_DEFAULT, 8'd4, reset value of the break gap in cycles.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_n  in  1  reset, synchronous and active-low
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte enables
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- active  out  32  one-hot project enable (bit n = project n)
- busy  out  1  switch sequence in progress
- switch_done  out  1  one-cycle pulse when a new selection takes effect

Behaviour:
- Reset (wb_rst_n=0 at a clock edge):
  - active=0, busy=0, switch_done=0, wbs_ack_o=0, wbs_dat_o=0.
  - cur_sel=0, cur_en=0, pend_sel=0, pend_en=0, gap=GAP_DEFAULT, err=0, count=0.
  - State goes to IDLE. Reset mid-switch aborts the switch immediately.
- Registers (offset = adr[3:2]; byte enables honoured per lane):
  - 0x0 CTRL, RW: [4:0] sel, [8] en. Reads return pend_sel/pend_en.
  - 0x4 STATUS, RO: [4:0] cur_sel, [8] cur_en, [9] busy, [10] err, [23:16] count. Writes are acked and ignored.
  - 0x8 GAP, RW: [7:0] gap. A written value of 0 is stored as 1.
  - Offset 0xC reads 0; writes to it are ignored.
- Wishbone handshake:
  - A request is stb&cyc&!ack with adr[31:4]==BASE_ADDR[31:4].
  - wbs_ack_o=1 on the next cycle for exactly one cycle; wbs_dat_o is valid in that cycle and 0 otherwise.
  - Back-to-back requests therefore complete every 2 cycles.
  - No ack is given for addresses outside the window.
- CTRL write handling:
  - en=1 with sel>=NUM_PROJECTS: err=1, pend unchanged, no switch.
  - Any other CTRL write: err=0, pend<=written value.
  - The request is "new" if (pend_en,pend_sel != cur_en,cur_sel), where cur_sel is ignored when both en bits are 0.
- FSM:
  - IDLE:
    - active = cur_en ? (1<<cur_sel) : 0; busy=0.
    - If pend differs from cur, go to BREAK next cycle with gap_cnt<=gap.
  - BREAK:
    - active=0, busy=1.
    - gap_cnt decrements each cycle; when gap_cnt==1, go to MAKE.
    - Result: active is 0 for exactly `gap` cycles.
  - MAKE (one cycle):
    - cur<=pend; active=0; busy=1.
    - Next cycle: IDLE drives the new active, and switch_done pulses in that first IDLE cycle.
    - count<=count+1 (8-bit, wraps 255->0).
- Latency: the CTRL write is acked at cycle A. Cycles A+1..A+gap have active=0. Cycle A+gap+1 is MAKE. The new one-hot appears at A+gap+2.
- CTRL writes during BREAK/MAKE:
  - pend is updated (latest wins); the in-flight sequence is not restarted.
  - MAKE samples pend at that cycle.
  - If pend changes after MAKE, IDLE starts a fresh sequence.
- GAP writes during BREAK affect only the next sequence.
- A write equal to the current selection in IDLE causes no switch and no count increment.
- en=0 request: runs the full sequence and ends with active=0, cur_en=0; count increments.
- Invariant: $onehot0(active) on every cycle. The FORMAL build asserts it.

Test Plan:
- Reset, then read STATUS -> 0x0000_0000. Read GAP -> 0x4. active=0. Ack arrives 1 cycle after stb.
- Write CTRL=0x103 (en, sel 3) with gap 4 -> ack at A; active=0 for A+1..A+4; active=0x0000_0008 at A+6; switch_done pulses at A+6; STATUS=0x0001_0103.
- From project 3, write GAP=0 then CTRL=0x101 -> gap reads 1; active 0x8 -> 0 for exactly 1 cycle -> 0x2 after MAKE; count=2.
- Write CTRL=0x105 then 0x102 during BREAK -> exactly one switch at the first MAKE, ending with active=0x4; no intermediate 0x20; count +1.
- Write CTRL=0x120 with NUM_PROJECTS=32 -> err=1 (STATUS[10]), active unchanged; a subsequent valid write clears err.
- Drive wb_rst_n=0 for one cycle mid-BREAK -> next cycle active=0, busy=0, STATUS=0. Assert onehot0(active) throughout every test.
